rd_writeback_regfile: RTL and testbench
=======================================

// Module: rd_writeback_regfile
// PURPOSE
//  Write-back end of the ALU result path: accepts {rd_write_control, rd_addr, rd_write_val}
//  from execute, queues it in a small in-order FIFO and retires one entry per cycle into
//  the NREGS x XLEN architectural register file. Supplies the rs1_val/rs2_val read operands
//  that feed the ALU. A load-unit write port has priority over FIFO drain.
// PARAMETERS
//  XLEN        32  data width of registers and write/read values
//  NREGS       32  number of architectural registers; x0 hardwired to zero
//  FIFO_DEPTH   2  pending write-back entries (>=1)
// PORTS
//  clk               in   1     single clock, all state updates on rising edge
//  rst_n             in   1     synchronous, active-low reset
//  wb_valid          in   1     execute presents a write-back request
//  wb_ready          out  1     block accepts request this cycle
//  rd_write_control  in   1     request really writes rd (0 = no-op)
//  rd_addr           in   5     destination register index
//  rd_write_val      in   XLEN  destination value
//  lsu_wr_en         in   1     load-unit write, priority over FIFO drain
//  lsu_wr_addr       in   5     load-unit destination index
//  lsu_wr_data       in   XLEN  load-unit value
//  rs1_addr          in   5     read port 1 index
//  rs2_addr          in   5     read port 2 index
//  rs1_val           out  XLEN  read port 1 data (combinational)
//  rs2_val           out  XLEN  read port 2 data (combinational)
//  wb_pending        out  1     FIFO non-empty
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all registers 0, FIFO emptied, count 0. While rst_n=0,
//    wb_ready=0 and lsu writes ignored. Reset mid-operation discards all pending entries.
//  - wb_ready = rst_n && (count < FIFO_DEPTH); no enqueue when full, even if draining.
//  - Handshake: transfer on wb_valid && wb_ready at edge. Payload sampled only then.
//    Transfers with rd_write_control=0 or rd_addr=0 are consumed and discarded.
//  - Drain: each edge with count>0 and lsu_wr_en=0 writes FIFO head to regfile, pops it.
//    lsu_wr_en=1 stalls drain for that cycle; lsu_wr_addr=0 writes nothing.
//  - Ordering: an LSU write is older than every FIFO entry; a later drain to the same
//    register overwrites it. Entries retire strictly in acceptance order.
//  - Simultaneous push+pop (not full): count unchanged, pointers both advance, wrap mod
//    FIFO_DEPTH.
//  - Latency: accepted at edge N -> earliest regfile write at edge N+1.
//  - Reads: index 0 returns 0 always. Otherwise per CONFIGURATION.
//  - wb_pending = (count != 0), registered-state derived, 0 after reset.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: read priority for index r (r!=0): youngest FIFO entry with
//    rd_addr==r > older FIFO entries > same-cycle lsu write to r > regfile contents.
//    Same-cycle wb transfer is not forwarded (visible from next cycle).
//  REGFILE_BYPASS_EN undefined: reads return regfile contents only; pending and same-cycle
//    LSU writes invisible until written. Queue/drain behaviour identical.
// TESTING
//  1. rst_n=0 2 cycles, read x5 -> rs1_val=0, wb_ready=0; rst_n=1 -> wb_ready=1, pending=0.
//  2. Push x5=0xDEADBEEF -> next cycle regfile x5=0xDEADBEEF, pending back to 0;
//     with bypass x5 reads 0xDEADBEEF in cycle after accept.
//  3. Push rd_addr=0 val 0x1234, and rd_write_control=0 to x3 -> nothing queued,
//     pending=0, x0=0, x3 unchanged.
//  4. lsu_wr_en=1 (x9=0x55) 3 cycles while pushing x1=1,x2=2,x4=4 -> wb_ready=0 after 2
//     accepts; after lsu drops, drains in order, x4 accepted, finally x1=1,x2=2,x4=4,x9=0x55.
//  5. lsu stall; push x7=1 then x7=2 -> bypass: x7 reads 2; no bypass: old value until
//     both drain, final x7=2.
//  6. Two entries pending, rst_n=0 one cycle -> pending=0, all registers read 0.

Source files
------------

// File: rtl/rd_writeback_regfile.sv
// Write-back FIFO and NREGS x XLEN register file with two combinational read ports.
// Optional macro REGFILE_BYPASS_EN forwards pending FIFO entries and same-cycle LSU writes to reads.
//
// Ports:
//   clk, rst_n (sync, active-low)
//   wb_valid/wb_ready + rd_write_control, rd_addr, rd_write_val : execute write-back request
//   lsu_wr_en, lsu_wr_addr, lsu_wr_data                         : load-unit write (beats drain)
//   rs1_addr/rs1_val, rs2_addr/rs2_val                          : read ports
//   wb_pending                                                  : FIFO non-empty
module rd_writeback_regfile #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic            rd_write_control,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_write_val,
    input  logic            lsu_wr_en,
    input  logic [4:0]      lsu_wr_addr,
    input  logic [XLEN-1:0] lsu_wr_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic            wb_pending
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [4:0]      fifo_addr_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic            push, pop, lsu_we, rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wb_ready   = rst_n && (count_q < CW'(FIFO_DEPTH));
    assign wb_pending = (count_q != '0);

    // Requests that would not change state are accepted but never enqueued.
    assign push   = wb_valid && wb_ready && rd_write_control && (rd_addr != 5'd0);
    assign lsu_we = rst_n && lsu_wr_en && (lsu_wr_addr != 5'd0);
    // Any LSU request, even to x0, steals the write port for the cycle.
    assign pop    = rst_n && !lsu_wr_en && (count_q != '0);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (lsu_we) begin
            rf_we    = 1'b1;
            rf_waddr = lsu_wr_addr;
            rf_wdata = lsu_wr_data;
        end else if (pop) begin
            rf_we    = 1'b1;
            rf_waddr = fifo_addr_q[head_q];
            rf_wdata = fifo_data_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = ptr_inc(tail_q);
        if (pop)  head_d = ptr_inc(head_q);
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[tail_q] <= rd_addr;
            fifo_data_q[tail_q] <= rd_write_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    logic [4:0]      rd_a [2];
    logic [XLEN-1:0] rd_v [2];

    assign rd_a[0] = rs1_addr;
    assign rd_a[1] = rs2_addr;
    assign rs1_val = rd_v[0];
    assign rs2_val = rd_v[1];

`ifdef REGFILE_BYPASS_EN
    // Walk FIFO oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW:0]   s;
        logic [PW-1:0] idx;
        s   = '0;
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            rd_v[p] = regs_q[rd_a[p]];
            if (lsu_we && (lsu_wr_addr == rd_a[p])) rd_v[p] = lsu_wr_data;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                s = {1'b0, head_q} + (PW+1)'(i);
                if (s >= (PW+1)'(FIFO_DEPTH)) s = s - (PW+1)'(FIFO_DEPTH);
                idx = s[PW-1:0];
                if ((CW'(i) < count_q) && (fifo_addr_q[idx] == rd_a[p]))
                    rd_v[p] = fifo_data_q[idx];
            end
            if (rd_a[p] == 5'd0) rd_v[p] = '0;
        end
    end
`else
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_v[p] = regs_q[rd_a[p]];
            if (rd_a[p] == 5'd0) rd_v[p] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_rd_writeback_regfile.sv
// Scoreboard bench for rd_writeback_regfile: directed scenarios then random traffic.
// Expected values come from a queue-based behavioural model.
module tb_rd_writeback_regfile;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst_n;
    logic            wb_valid;
    logic            wb_ready;
    logic            rd_write_control;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_write_val;
    logic            lsu_wr_en;
    logic [4:0]      lsu_wr_addr;
    logic [XLEN-1:0] lsu_wr_data;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            wb_pending;

    rd_writeback_regfile #(.XLEN(XLEN), .NREGS(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .rd_write_control(rd_write_control), .rd_addr(rd_addr),
        .rd_write_val(rd_write_val),
        .lsu_wr_en(lsu_wr_en), .lsu_wr_addr(lsu_wr_addr),
        .lsu_wr_data(lsu_wr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .wb_pending(wb_pending)
    );

    // Negedge at 5, posedge at 10: inputs driven after posedge, checked at negedge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        rdy;
        logic        pend;
    } exp_t;

    logic [31:0] mregs [32];
    ent_t        mfifo [$];
    exp_t        expq  [$];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        for (int i = mfifo.size() - 1; i >= 0; i--)
            if (mfifo[i].a == a) return mfifo[i].d;
        if (rst_n && lsu_wr_en && lsu_wr_addr == a) return lsu_wr_data;
`endif
        return mregs[a];
    endfunction

    task automatic model_edge();
        bit take;
        ent_t e;
        take = wb_valid && (mfifo.size() < DEPTH);
        if (!rst_n) begin
            foreach (mregs[i]) mregs[i] = 32'd0;
            mfifo.delete();
        end else begin
            if (lsu_wr_en) begin
                if (lsu_wr_addr != 5'd0) mregs[lsu_wr_addr] = lsu_wr_data;
            end else if (mfifo.size() > 0) begin
                e = mfifo.pop_front();
                mregs[e.a] = e.d;
            end
            if (take && rd_write_control && rd_addr != 5'd0) begin
                e.a = rd_addr;
                e.d = rd_write_val;
                mfifo.push_back(e);
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic ctl,
                        input logic [4:0] ra, input logic [31:0] rv,
                        input logic le, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input bit chk = 1'b1);
        exp_t e;
        rst_n = rst; wb_valid = v; rd_write_control = ctl;
        rd_addr = ra; rd_write_val = rv;
        lsu_wr_en = le; lsu_wr_addr = la; lsu_wr_data = ld;
        rs1_addr = a1; rs2_addr = a2;
        if (chk) begin
            e.a1 = a1; e.a2 = a2;
            e.r1 = model_read(a1);
            e.r2 = model_read(a2);
            e.rdy = rst && (mfifo.size() < DEPTH);
            e.pend = (mfifo.size() != 0);
            expq.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        step(1, 0, 0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h expected %h", nm, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk($sformatf("rs1 x%0d", e.a1), rs1_val, e.r1);
                chk($sformatf("rs2 x%0d", e.a2), rs2_val, e.r2);
                chk("wb_ready", {31'd0, wb_ready}, {31'd0, e.rdy});
                chk("wb_pending", {31'd0, wb_pending}, {31'd0, e.pend});
            end
        end
    end

    initial begin
        foreach (mregs[i]) mregs[i] = 32'd0;
        // 1: reset, first cycle unchecked since state is undefined before the first edge
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        step(0, 1, 1, 5, 32'h1111, 1, 5, 32'h2222, 5, 0);
        idle(5, 5);
        // 2: single write-back
        step(1, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        idle(5, 0);
        idle(5, 0);
        // 3: discarded transfers
        step(1, 1, 1, 0, 32'h1234, 0, 0, 0, 0, 3);
        step(1, 1, 0, 3, 32'hABCD, 0, 0, 0, 0, 3);
        idle(0, 3);
        // 4: LSU stall while pushing; x4 re-presented until accepted
        step(1, 1, 1, 1, 32'd1, 1, 9, 32'h55, 1, 9);
        step(1, 1, 1, 2, 32'd2, 1, 9, 32'h55, 2, 9);
        step(1, 1, 1, 4, 32'd4, 1, 9, 32'h55, 4, 9);
        step(1, 1, 1, 4, 32'd4, 0, 0, 0, 1, 4);
        step(1, 1, 1, 4, 32'd4, 0, 0, 0, 2, 4);
        idle(1, 2);
        idle(4, 9);
        idle(1, 2);
        // 5: two pending writes to the same register
        step(1, 1, 1, 7, 32'd1, 1, 0, 0, 7, 0);
        step(1, 1, 1, 7, 32'd2, 1, 0, 0, 7, 0);
        idle(7, 0);
        idle(7, 0);
        idle(7, 0);
        // 6: reset with entries pending
        step(1, 1, 1, 10, 32'hA, 1, 0, 0, 10, 0);
        step(1, 1, 1, 11, 32'hB, 1, 0, 0, 11, 10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 11, 10);
        idle(11, 10);
        idle(5, 7);
        // random traffic on a small register subset to force address collisions
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(63) != 0),
                 ($urandom_range(3) != 0), ($urandom_range(7) != 0),
                 5'($urandom_range(7)), $urandom(),
                 ($urandom_range(3) == 0), 5'($urandom_range(7)), $urandom(),
                 5'($urandom_range(7)), 5'($urandom_range(31)));
        end
        for (int n = 0; n < 4; n++) idle(0, 0);
        for (int r = 0; r < 32; r += 2) idle(5'(r), 5'(r + 1));
        repeat (2) @(negedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
